// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, default widths and the RAM-port
// layout the CPU top muxes against. PROG_LOADER_VERIFY_EN adds the read-back states.
package prog_loader_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StRecv  = 3'd2,
    StWrite = 3'd3,
`ifdef PROG_LOADER_VERIFY_EN
    StVrd   = 3'd6,
    StVcmp  = 3'd7,
`endif
    StRun   = 3'd4,
    StDone  = 3'd5
  } state_e;

  // Bit layout of one RAM-port bus beat, identical for loader and CPU masters.
  typedef struct packed {
    logic [DefAddrW-1:0] addr;
    logic [DefDataW-1:0] data;
    logic                wren;
    logic                rden;
  } ram_port_t;

  localparam int unsigned RamPortW = $bits(ram_port_t);

  // The CPU is held in every loader-owned state up to the run pulse.
  function automatic logic halt_state(state_e s);
    return !(s inside {StIdle, StRun, StDone});
  endfunction

endpackage

// File: rtl/loader_addr_ctr.sv
// RAM write pointer (load to BASE_ADDR, increment mod 2^ADDR_W) plus a byte counter whose
// terminal flag marks the byte that would bring the count to MAX_LEN.
module loader_addr_ctr #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              term_o
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (load_i) begin
      ptr_d   = ADDR_W'(BASE_ADDR);
      count_d = '0;
    end else if (inc_i) begin
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= ADDR_W'(BASE_ADDR);
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign term_o = (count_q == CntW'(MAX_LEN - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a host byte stream into RAM while the CPU is held, then pulses cpu_run.
// Define PROG_LOADER_VERIFY_EN to read back and compare every byte after writing it.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_LEN   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              cpu_halt,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  logic              in_ready_q, in_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              cpu_halt_q, cpu_halt_d;
  logic              cpu_run_q, cpu_run_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ctr_load, ctr_inc, ctr_term;
  logic [ADDR_W-1:0] ptr;

  state_e            succ_state;
  logic              succ_err;
  logic              succ_term;

  loader_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .MAX_LEN   (MAX_LEN)
  ) u_addr_ctr (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (ctr_load),
    .inc_i  (ctr_inc),
    .ptr_o  (ptr),
    .term_o (ctr_term)
  );

`ifdef PROG_LOADER_VERIFY_EN
  logic term_q, term_d;
  logic mem_rden_q, mem_rden_d;

  // The count has already advanced by VCMP, so the terminal flag is kept from WRITE.
  assign succ_term = term_q;
  assign mem_rden  = mem_rden_q;
`else
  logic unused_mem_q;

  assign unused_mem_q = ^mem_q;
  assign succ_term    = ctr_term;
  assign mem_rden     = 1'b0;
`endif

  // Where a successfully stored byte leads: last wins over the length limit.
  always_comb begin
    succ_err = 1'b0;
    if (last_q) begin
      succ_state = StRun;
    end else if (succ_term) begin
      succ_state = StDone;
      succ_err   = 1'b1;
    end else begin
      succ_state = StRecv;
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    data_d   = data_q;
    last_d   = last_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
    term_d   = term_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StHalt;
          err_d    = 1'b0;
          ctr_load = 1'b1;
        end
      end
      StHalt: state_d = StRecv;
      StRecv: begin
        if (in_valid) begin
          data_d  = in_data;
          last_d  = in_last;
          state_d = StWrite;
        end
      end
      StWrite: begin
        ctr_inc = 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
        term_d  = ctr_term;
        state_d = StVrd;
`else
        state_d = succ_state;
        if (succ_err) err_d = 1'b1;
`endif
      end
`ifdef PROG_LOADER_VERIFY_EN
      StVrd: state_d = StVcmp;
      StVcmp: begin
        if (mem_q != data_q) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = succ_state;
          if (succ_err) err_d = 1'b1;
        end
      end
`endif
      StRun:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    in_ready_d = (state_d == StRecv);
    mem_wren_d = (state_d == StWrite);
    mem_addr_d = '0;
    mem_data_d = '0;
    if (state_d == StWrite) begin
      mem_addr_d = ptr;
      mem_data_d = data_d;
    end
`ifdef PROG_LOADER_VERIFY_EN
    mem_rden_d = (state_d == StVrd);
    if (state_d == StVrd) mem_addr_d = ptr;
`endif
    cpu_halt_d = halt_state(state_d);
    cpu_run_d  = (state_d == StRun);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_wren_q <= 1'b0;
      cpu_halt_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      term_q     <= 1'b0;
      mem_rden_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      data_q     <= data_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_wren_q <= mem_wren_d;
      cpu_halt_q <= cpu_halt_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PROG_LOADER_VERIFY_EN
      term_q     <= term_d;
      mem_rden_q <= mem_rden_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;
  assign cpu_halt = cpu_halt_q;
  assign cpu_run  = cpu_run_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
